// File: rtl/sdlc_rx_deframer.sv
// sdlc_rx_deframer: SDLC/HDLC receive deframer.
// Hunts 0x7E flags, removes stuffed zeros, detects aborts and misaligned
// closing flags, checks a reflected CRC and strips the FCS, then packs the
// payload into WORD_BYTES-wide entries of a first-word-fall-through FIFO.
module sdlc_rx_deframer #(
    parameter int               WORD_BYTES  = 2,
    parameter int               DEPTH       = 4,
    parameter int               CRC_W       = 16,
    parameter logic [CRC_W-1:0] CRC_POLY    = 16'h8408,
    parameter logic [CRC_W-1:0] CRC_INIT    = 16'hFFFF,
    parameter logic [CRC_W-1:0] CRC_RESIDUE = 16'hF0B8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             bit_en,
    input  logic                             rx_data,
    output logic [8*WORD_BYTES-1:0]          out_data,
    output logic [$clog2(WORD_BYTES+1)-1:0]  out_nbytes,
    output logic                             out_last,
    output logic [4:0]                       out_status,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             in_frame,
    output logic                             overrun_sticky,
    input  logic                             clear
);

    localparam int CRC_BYTES = CRC_W / 8;
    localparam int DW        = 8 * WORD_BYTES;
    localparam int NBW       = $clog2(WORD_BYTES + 1);
    localparam int AW        = $clog2(DEPTH);
    localparam int CW        = AW + 1;
    localparam int BCW       = $clog2(CRC_BYTES + 2);
    localparam int LAST_BIT  = DW + NBW;
    localparam int EW        = DW + NBW + 6;

    localparam logic [1:0] ST_HUNT = 2'd0;
    localparam logic [1:0] ST_FLAG = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // One byte of the reflected CRC, LSB first, eight unrolled steps.
    function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c,
                                                  input logic [7:0]       b);
        logic [CRC_W-1:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) begin
                r = (r >> 1) ^ CRC_POLY;
            end else begin
                r = r >> 1;
            end
        end
        return r;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [2:0]       ones_q, ones_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [7:0]       dly_q [CRC_BYTES];
    logic [7:0]       dly_d [CRC_BYTES];
    logic [BCW-1:0]   bcnt_q, bcnt_d;
    logic [DW-1:0]    pk_data_q, pk_data_d;
    logic [NBW-1:0]   pk_n_q, pk_n_d;
    logic             frm_ovr_q, frm_ovr_d;
    logic             push_q, push_d;
    logic [EW-1:0]    push_ent_q, push_ent_d;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sticky_q, sticky_d;

    logic             is_data_s, is_flag_s, is_abort_s, byte_done_s, runt_s;
    logic [7:0]       byte_s;
    logic [4:0]       status_s;
    logic             pop_s, acc_s, drop_s;
    logic [EW-1:0]    head_s;

    // Raw-bit classification: stuffed zero, flag, abort or data bit.
    always_comb begin
        ones_d     = ones_q;
        is_data_s  = 1'b0;
        is_flag_s  = 1'b0;
        is_abort_s = 1'b0;
        if (bit_en) begin
            if (rx_data) begin
                ones_d = (ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1;
                if (ones_q == 3'd6) begin
                    is_abort_s = 1'b1;
                end else begin
                    is_data_s = 1'b1;
                end
            end else begin
                ones_d = 3'd0;
                if (ones_q == 3'd6) begin
                    is_flag_s = 1'b1;
                end else if (ones_q == 3'd5) begin
                    is_data_s = 1'b0;
                end else begin
                    is_data_s = 1'b1;
                end
            end
        end else begin
            ones_d = ones_q;
        end
    end

    assign byte_s      = {rx_data, shreg_q[7:1]};
    assign byte_done_s = is_data_s && (bitcnt_q == 3'd7);
    assign runt_s      = (bcnt_q <= BCW'(CRC_BYTES));

    // Frame FSM, assembler, CRC, FCS delay line, packer and push request.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        crc_d      = crc_q;
        dly_d      = dly_q;
        bcnt_d     = bcnt_q;
        pk_data_d  = pk_data_q;
        pk_n_d     = pk_n_q;
        frm_ovr_d  = frm_ovr_q | (drop_s & ~push_ent_q[LAST_BIT]);
        push_d     = 1'b0;
        push_ent_d = push_ent_q;
        status_s   = 5'b00000;

        if (is_data_s) begin
            shreg_d  = byte_s;
            bitcnt_d = bitcnt_q + 3'd1;
        end else begin
            shreg_d  = shreg_q;
            bitcnt_d = bitcnt_q;
        end

        if (is_flag_s || is_abort_s) begin
            // The 7 bits before an aligned flag are its own prefix; they
            // never completed a byte, so crc_q still covers the last octet.
            status_s[0] = is_flag_s && (bitcnt_q == 3'd7) && !runt_s &&
                          (crc_q != CRC_RESIDUE);
            status_s[1] = is_abort_s;
            status_s[2] = is_flag_s && (bitcnt_q != 3'd7);
            status_s[3] = frm_ovr_q;
            status_s[4] = runt_s;
            if (state_q == ST_DATA) begin
                push_d     = 1'b1;
                push_ent_d = {status_s, 1'b1, pk_n_q, pk_data_q};
            end else begin
                push_d     = 1'b0;
                push_ent_d = push_ent_q;
            end
            bitcnt_d  = 3'd0;
            crc_d     = CRC_INIT;
            for (int i = 0; i < CRC_BYTES; i++) begin
                dly_d[i] = 8'h00;
            end
            bcnt_d    = '0;
            pk_data_d = '0;
            pk_n_d    = '0;
            frm_ovr_d = 1'b0;
            state_d   = is_abort_s ? ST_HUNT : ST_FLAG;
        end else if (byte_done_s && (state_q != ST_HUNT)) begin
            state_d = ST_DATA;
            crc_d   = crc_byte(crc_q, byte_s);
            for (int i = CRC_BYTES - 1; i > 0; i--) begin
                dly_d[i] = dly_q[i-1];
            end
            dly_d[0] = byte_s;
            if (bcnt_q != BCW'(CRC_BYTES + 1)) begin
                bcnt_d = bcnt_q + BCW'(1);
            end else begin
                bcnt_d = bcnt_q;
            end
            // Only a byte pushed out of the full delay line is payload.
            if (bcnt_q >= BCW'(CRC_BYTES)) begin
                for (int i = 0; i < WORD_BYTES; i++) begin
                    pk_data_d[8*i +: 8] = (NBW'(i) == pk_n_q) ? dly_q[CRC_BYTES-1]
                                                             : pk_data_q[8*i +: 8];
                end
                if (pk_n_q == NBW'(WORD_BYTES - 1)) begin
                    push_d     = 1'b1;
                    push_ent_d = {5'b00000, 1'b0, NBW'(WORD_BYTES), pk_data_d};
                    pk_data_d  = '0;
                    pk_n_d     = '0;
                end else begin
                    pk_n_d = pk_n_q + NBW'(1);
                end
            end else begin
                pk_data_d = pk_data_q;
                pk_n_d    = pk_n_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // FIFO accept/drop decision and pointer/count/sticky next state.
    always_comb begin
        pop_s  = (cnt_q != '0) && out_ready;
        acc_s  = push_q && ((cnt_q != CW'(DEPTH)) || pop_s);
        drop_s = push_q && !acc_s;
        wr_d   = acc_s ? wr_q + AW'(1) : wr_q;
        rd_d   = pop_s ? rd_q + AW'(1) : rd_q;
        if (acc_s && !pop_s) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!acc_s && pop_s) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (drop_s) begin
            sticky_d = 1'b1;
        end else if (clear) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_HUNT;
            ones_q     <= 3'd0;
            shreg_q    <= 8'h00;
            bitcnt_q   <= 3'd0;
            crc_q      <= CRC_INIT;
            for (int i = 0; i < CRC_BYTES; i++) begin
                dly_q[i] <= 8'h00;
            end
            bcnt_q     <= '0;
            pk_data_q  <= '0;
            pk_n_q     <= '0;
            frm_ovr_q  <= 1'b0;
            push_q     <= 1'b0;
            push_ent_q <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ones_q     <= ones_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            crc_q      <= crc_d;
            dly_q      <= dly_d;
            bcnt_q     <= bcnt_d;
            pk_data_q  <= pk_data_d;
            pk_n_q     <= pk_n_d;
            frm_ovr_q  <= frm_ovr_d;
            push_q     <= push_d;
            push_ent_q <= push_ent_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            sticky_q   <= sticky_d;
        end
    end

    // FIFO storage; contents are masked at the outputs while empty.
    always_ff @(posedge clk) begin
        if (acc_s) begin
            mem_q[wr_q] <= push_ent_q;
        end
    end

    assign out_valid      = (cnt_q != '0);
    assign head_s         = out_valid ? mem_q[rd_q] : '0;
    assign out_data       = head_s[DW-1:0];
    assign out_nbytes     = head_s[DW +: NBW];
    assign out_last       = head_s[LAST_BIT];
    assign out_status     = head_s[LAST_BIT+1 +: 5];
    assign in_frame       = (state_q == ST_DATA);
    assign overrun_sticky = sticky_q;

endmodule

// File: tb/tb_sdlc_rx_deframer.sv
// tb_sdlc_rx_deframer: directed bench for the SDLC receive deframer.
module tb_sdlc_rx_deframer;

    logic        clk = 1'b0;
    logic        reset, bit_en, rx_data, out_ready, clear;
    logic [15:0] out_data;
    logic [1:0]  out_nbytes;
    logic        out_last, out_valid, in_frame, overrun_sticky;
    logic [4:0]  out_status;

    int          err_cnt = 0;
    int          chk_cnt = 0;
    int          tx_ones = 0;
    logic [23:0] rxq [$];
    logic [15:0] fcs_ff;

    sdlc_rx_deframer dut (
        .clk(clk), .reset(reset), .bit_en(bit_en), .rx_data(rx_data),
        .out_data(out_data), .out_nbytes(out_nbytes), .out_last(out_last),
        .out_status(out_status), .out_valid(out_valid), .out_ready(out_ready),
        .in_frame(in_frame), .overrun_sticky(overrun_sticky), .clear(clear)
    );

    always #5 clk = ~clk;

    // Collect every popped entry as {status, last, nbytes, data}.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            rxq.push_back({out_status, out_last, out_nbytes, out_data});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_entry(input string tag, input int idx, input logic [15:0] d,
                             input logic [1:0] nb, input logic last, input logic [4:0] st);
        logic [23:0] got;
        got = (idx < rxq.size()) ? rxq[idx] : 24'bx;
        chk(tag, {8'h00, got}, {8'h00, st, last, nb, d});
    endtask

    // CRC-16 reflected, poly 0x8408, one byte LSB first.
    function automatic logic [15:0] model_crc(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = {1'b0, r[15:1]};
            if (fb) r = r ^ 16'h8408;
        end
        return r;
    endfunction

    task automatic send_raw(input logic b);
        rx_data = b;
        bit_en  = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send_data_bit(input logic b);
        send_raw(b);
        if (b) begin
            tx_ones++;
            if (tx_ones == 5) begin
                send_raw(1'b0);
                tx_ones = 0;
            end
        end else begin
            tx_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_data_bit(b[i]);
    endtask

    task automatic send_list(input logic [7:0] lst [$]);
        foreach (lst[i]) send_byte(lst[i]);
    endtask

    task automatic send_flag();
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 8; i++) send_raw(f[i]);
        tx_ones = 0;
    endtask

    initial begin
        reset = 1'b1; bit_en = 1'b0; rx_data = 1'b1; out_ready = 1'b1; clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_inframe", {31'd0, in_frame}, 32'd0);
        chk("rst_sticky", {31'd0, overrun_sticky}, 32'd0);
        chk("rst_data", {16'd0, out_data}, 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Good frame "123456789" with FCS 6E 90.
        rxq.delete();
        send_flag(); send_flag(); send_flag();
        send_byte(8'h31);
        chk("inframe_rise", {31'd0, in_frame}, 32'd1);
        send_list('{8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90});
        send_flag();
        chk("inframe_fall", {31'd0, in_frame}, 32'd0);
        chk("good_cnt", rxq.size(), 32'd5);
        chk_entry("good_e0", 0, 16'h3231, 2'd2, 1'b0, 5'b00000);
        chk_entry("good_e1", 1, 16'h3433, 2'd2, 1'b0, 5'b00000);
        chk_entry("good_e2", 2, 16'h3635, 2'd2, 1'b0, 5'b00000);
        chk_entry("good_e3", 3, 16'h3837, 2'd2, 1'b0, 5'b00000);
        chk_entry("good_last", 4, 16'h0039, 2'd1, 1'b1, 5'b00000);

        // Same frame with last payload byte corrupted.
        rxq.delete();
        send_list('{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h38, 8'h6E, 8'h90});
        send_flag();
        chk("crc_cnt", rxq.size(), 32'd5);
        chk_entry("crc_e0", 0, 16'h3231, 2'd2, 1'b0, 5'b00000);
        chk_entry("crc_last", 4, 16'h0038, 2'd1, 1'b1, 5'b00001);

        // Stuffed payload FF FF with correct FCS.
        fcs_ff = ~model_crc(model_crc(16'hFFFF, 8'hFF), 8'hFF);
        rxq.delete();
        send_list('{8'hFF, 8'hFF, fcs_ff[7:0], fcs_ff[15:8]});
        send_flag();
        chk("ff_cnt", rxq.size(), 32'd2);
        chk_entry("ff_e0", 0, 16'hFFFF, 2'd2, 1'b0, 5'b00000);
        chk_entry("ff_last", 1, 16'h0000, 2'd0, 1'b1, 5'b00000);

        // Same, with one extra bit before the flag: misaligned close.
        rxq.delete();
        send_list('{8'hFF, 8'hFF, fcs_ff[7:0], fcs_ff[15:8]});
        send_data_bit(1'b0);
        send_flag();
        chk("align_cnt", rxq.size(), 32'd2);
        chk_entry("align_e0", 0, 16'hFFFF, 2'd2, 1'b0, 5'b00000);
        chk_entry("align_last", 1, {8'h00, fcs_ff[7:0]}, 2'd1, 1'b1, 5'b00100);

        // Abort after three bytes, then unflagged data is ignored.
        rxq.delete();
        send_flag();
        send_list('{8'h11, 8'h22, 8'h33});
        for (int i = 0; i < 7; i++) send_raw(1'b1);
        tx_ones = 0;
        chk("abort_cnt", rxq.size(), 32'd1);
        chk_entry("abort_last", 0, 16'h0011, 2'd1, 1'b1, 5'b00010);
        chk("abort_inframe", {31'd0, in_frame}, 32'd0);
        send_list('{8'h41, 8'h42, 8'h43});
        chk("hunt_noentry", rxq.size(), 32'd1);
        chk("hunt_inframe", {31'd0, in_frame}, 32'd0);

        // Runt frame of two bytes.
        rxq.delete();
        send_flag();
        send_list('{8'hAA, 8'h55});
        send_flag();
        chk("runt_cnt", rxq.size(), 32'd1);
        chk_entry("runt_last", 0, 16'h0000, 2'd0, 1'b1, 5'b10000);

        // Overrun: FIFO not drained during a 9-byte frame.
        rxq.delete();
        out_ready = 1'b0;
        send_list('{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90});
        send_flag();
        chk("ovr_sticky", {31'd0, overrun_sticky}, 32'd1);
        chk("ovr_valid", {31'd0, out_valid}, 32'd1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clear_sticky", {31'd0, overrun_sticky}, 32'd0);
        // Runt frame whose closing entry is dropped on the same edge as clear.
        send_list('{8'hAA, 8'h55});
        for (int i = 0; i < 7; i++) send_raw((i == 0) ? 1'b0 : 1'b1);
        rx_data = 1'b0;
        bit_en  = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        clear  = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        tx_ones = 0;
        chk("set_wins", {31'd0, overrun_sticky}, 32'd1);
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("ovr_kept", rxq.size(), 32'd4);
        chk_entry("ovr_e0", 0, 16'h3231, 2'd2, 1'b0, 5'b00000);
        chk_entry("ovr_e3", 3, 16'h3837, 2'd2, 1'b0, 5'b00000);
        chk("ovr_empty", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a frame with an entry buffered.
        rxq.delete();
        out_ready = 1'b0;
        send_flag();
        send_list('{8'hAA, 8'h55});
        send_flag();
        send_list('{8'h31, 8'h32});
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_inframe", {31'd0, in_frame}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_outs", {8'd0, out_data, out_nbytes, out_last, out_status}, 32'd0);
        chk("mrst_inframe", {31'd0, in_frame}, 32'd0);
        chk("mrst_sticky", {31'd0, overrun_sticky}, 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        tx_ones = 0;
        send_byte(8'h33);
        send_flag();
        repeat (5) @(posedge clk);
        #1;
        chk("mrst_discard", rxq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
